// File: rtl/dense_pkg.sv
// Shared constants and FSM encoding for the dense-layer parameter writers.
// Combinational only: no latency, no backpressure.
package dense_pkg;

    localparam int FLOAT = 32;

    localparam int DENSE1_NB_INPUT   = 42;
    localparam int DENSE1_NB_NEURONS = 24;
    localparam int DENSE2_NB_INPUT   = 24;
    localparam int DENSE2_NB_NEURONS = 1;
    localparam int DENSE3_NB_INPUT   = 96;
    localparam int DENSE3_NB_NEURONS = 22;

    localparam logic [31:0] WEIGHT_SCALE = 32'h3B800000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } wr_state_e;

    // Index width for an n-entry store; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_param_writer_if.sv
// Host-side load stream plus the packed parameter buses seen by the dense layer.
// Wires only: no latency; s_ready carries the writer's backpressure.
interface dense_param_writer_if #(
    parameter int FLOAT      = 32,
    parameter int NB_INPUT   = 42,
    parameter int NB_NEURONS = 24
);
    localparam int NB_W = NB_INPUT * NB_NEURONS;

    logic                         load_start;
    logic [FLOAT-1:0]             s_data;
    logic                         s_valid;
    logic                         s_last;
    logic                         s_ready;
    logic [NB_W*FLOAT-1:0]        weights;
    logic [NB_NEURONS*FLOAT-1:0]  bias;
    logic                         params_valid;
    logic                         load_err;
    logic                         busy;

    modport master (
        output load_start, s_data, s_valid, s_last,
        input  s_ready, weights, bias, params_valid, load_err, busy
    );

    modport slave (
        input  load_start, s_data, s_valid, s_last,
        output s_ready, weights, bias, params_valid, load_err, busy
    );

endinterface

// File: rtl/dense_param_bank.sv
// Indexed register store flattened onto a packed bus; write visible the cycle after we_i.
// No backpressure: every enabled write lands.
module dense_param_bank #(
    parameter int DEPTH = 1,
    parameter int FLOAT = 32,
    parameter int IW    = dense_pkg::idx_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [IW-1:0]          idx_i,
    input  logic [FLOAT-1:0]       dat_i,
    output logic [DEPTH*FLOAT-1:0] bus_o
);

    logic [DEPTH-1:0][FLOAT-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= dat_i;
        end
    end

    assign bus_o = mem_q;

endmodule

// File: rtl/dense_param_writer.sv
// Streams weight then bias words into the dense-layer stores; one word per cycle, written at the accept edge.
// s_ready comes from registered state only and drops outside LOAD_W/LOAD_B.
module dense_param_writer #(
    parameter int FLOAT      = dense_pkg::FLOAT,
    parameter int NB_INPUT   = dense_pkg::DENSE1_NB_INPUT,
    parameter int NB_NEURONS = dense_pkg::DENSE1_NB_NEURONS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dense_param_writer_if.slave  bus
);
    import dense_pkg::*;

    localparam int NB_W = NB_INPUT * NB_NEURONS;
    localparam int CW   = idx_width(NB_W);
    localparam int BW   = idx_width(NB_NEURONS);
    localparam logic [CW-1:0] W_LAST = CW'(NB_W - 1);
    localparam logic [CW-1:0] B_LAST = CW'(NB_NEURONS - 1);

    wr_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, busy_q, pv_q, err_q;
    logic            accept, we_w, we_b;

    assign accept = bus.s_valid & ready_q;
    // A restart discards any word accepted in the same cycle.
    assign we_w   = accept & ~bus.load_start & (state_q == ST_LOAD_W);
    assign we_b   = accept & ~bus.load_start & (state_q == ST_LOAD_B);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.load_start) begin
            state_d = ST_LOAD_W;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                ST_LOAD_W: begin
                    if (bus.s_last) begin
                        state_d = ST_ERR;
                    end else if (cnt_q == W_LAST) begin
                        state_d = ST_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD_B: begin
                    if (cnt_q == B_LAST) begin
                        state_d = bus.s_last ? ST_DONE : ST_ERR;
                    end else if (bus.s_last) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B);
            busy_q  <= (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B);
            pv_q    <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERR);
        end
    end

    dense_param_bank #(.DEPTH(NB_W), .FLOAT(FLOAT)) u_weights (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (we_w),
        .idx_i (cnt_q),
        .dat_i (bus.s_data),
        .bus_o (bus.weights)
    );

    dense_param_bank #(.DEPTH(NB_NEURONS), .FLOAT(FLOAT)) u_bias (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (we_b),
        .idx_i (cnt_q[BW-1:0]),
        .dat_i (bus.s_data),
        .bus_o (bus.bias)
    );

    assign bus.s_ready      = ready_q;
    assign bus.busy         = busy_q;
    assign bus.params_valid = pv_q;
    assign bus.load_err     = err_q;

endmodule

// File: tb/tb_dense_param_writer.sv
// Directed bench: a 3x2 writer for framing/restart cases, plus 42x24 and 24x1 writers for full-size loads.
module tb_dense_param_writer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dense_param_writer_if #(.FLOAT(32), .NB_INPUT(3),  .NB_NEURONS(2))  ifa ();
    dense_param_writer_if #(.FLOAT(32), .NB_INPUT(42), .NB_NEURONS(24)) ifb ();
    dense_param_writer_if #(.FLOAT(32), .NB_INPUT(24), .NB_NEURONS(1))  ifc ();

    dense_param_writer #(.FLOAT(32), .NB_INPUT(3),  .NB_NEURONS(2))  u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    dense_param_writer #(.FLOAT(32), .NB_INPUT(42), .NB_NEURONS(24)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    dense_param_writer #(.FLOAT(32), .NB_INPUT(24), .NB_NEURONS(1))  u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int k);
        return ifa.weights[k*32 +: 32];
    endfunction

    function automatic logic [31:0] ba(input int n);
        return ifa.bias[n*32 +: 32];
    endfunction

    task automatic start_a();
        ifa.load_start = 1'b1;
        tick();
        ifa.load_start = 1'b0;
    endtask

    task automatic word_a(input logic [31:0] d, input logic last);
        ifa.s_valid = 1'b1;
        ifa.s_data  = d;
        ifa.s_last  = last;
        tick();
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ifa.load_start = 0; ifa.s_data = '0; ifa.s_valid = 0; ifa.s_last = 0;
        ifb.load_start = 0; ifb.s_data = '0; ifb.s_valid = 0; ifb.s_last = 0;
        ifc.load_start = 0; ifc.s_data = '0; ifc.s_valid = 0; ifc.s_last = 0;

        // Reset with s_valid held high.
        rst_n = 1'b0;
        ifa.s_valid = 1'b1;
        repeat (3) tick();
        chk("rst_ready",   {31'b0, ifa.s_ready},        32'd0);
        chk("rst_pv",      {31'b0, ifa.params_valid},   32'd0);
        chk("rst_err",     {31'b0, ifa.load_err},       32'd0);
        chk("rst_busy",    {31'b0, ifa.busy},           32'd0);
        chk("rst_weights", {31'b0, (ifa.weights === '0)}, 32'd1);
        chk("rst_bias",    {31'b0, (ifa.bias === '0)},    32'd1);
        chk("rst_pv_b",    {31'b0, ifb.params_valid},   32'd0);
        chk("rst_pv_c",    {31'b0, ifc.params_valid},   32'd0);
        rst_n = 1'b1;
        ifa.s_valid = 1'b0;
        tick();
        chk("idle_ready",  {31'b0, ifa.s_ready},        32'd0);

        // Nominal back-to-back load.
        start_a();
        chk("nom_ready",   {31'b0, ifa.s_ready},        32'd1);
        chk("nom_busy",    {31'b0, ifa.busy},           32'd1);
        for (int i = 0; i < 8; i++) begin
            ifa.s_valid = 1'b1;
            ifa.s_data  = 32'h3F800000 + i;
            ifa.s_last  = (i == 7);
            tick();
            if (i == 6) chk("nom_pv_early", {31'b0, ifa.params_valid}, 32'd0);
        end
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
        chk("nom_pv",      {31'b0, ifa.params_valid},   32'd1);
        chk("nom_ready_lo",{31'b0, ifa.s_ready},        32'd0);
        chk("nom_busy_lo", {31'b0, ifa.busy},           32'd0);
        for (int k = 0; k < 6; k++) chk($sformatf("nom_w%0d", k), wa(k), 32'h3F800000 + k);
        for (int n = 0; n < 2; n++) chk($sformatf("nom_b%0d", n), ba(n), 32'h3F800006 + n);

        // Gapped load; idle cycles carry junk with s_last high.
        start_a();
        chk("gap_pv_fall", {31'b0, ifa.params_valid},   32'd0);
        for (int i = 0; i < 8; i++) begin
            word_a(32'h40000000 + i, (i == 7));
            if (i < 7) begin
                ifa.s_data = 32'hDEADBEEF;
                ifa.s_last = 1'b1;
                tick();
                tick();
                ifa.s_last = 1'b0;
            end
            if (i == 3) begin
                chk("gap_w3",  wa(3), 32'h40000003);
                chk("gap_w4_held", wa(4), 32'h3F800004);
                chk("gap_pv_mid", {31'b0, ifa.params_valid}, 32'd0);
            end
        end
        chk("gap_pv",      {31'b0, ifa.params_valid},   32'd1);
        for (int k = 0; k < 6; k++) chk($sformatf("gap_w%0d", k), wa(k), 32'h40000000 + k);
        for (int n = 0; n < 2; n++) chk($sformatf("gap_b%0d", n), ba(n), 32'h40000006 + n);

        // Early last on word 3.
        start_a();
        for (int i = 0; i < 4; i++) word_a(32'h70000000 + i, (i == 3));
        chk("early_err",   {31'b0, ifa.load_err},       32'd1);
        chk("early_pv",    {31'b0, ifa.params_valid},   32'd0);
        chk("early_ready", {31'b0, ifa.s_ready},        32'd0);
        chk("early_busy",  {31'b0, ifa.busy},           32'd0);
        chk("early_w3",    wa(3),                       32'h70000003);

        // Missing last: final bias word still written, then error.
        start_a();
        chk("miss_err_clr",{31'b0, ifa.load_err},       32'd0);
        for (int i = 0; i < 8; i++) begin
            word_a(32'h60000000 + i, 1'b0);
            if (i == 6) chk("miss_err_early", {31'b0, ifa.load_err}, 32'd0);
        end
        chk("miss_err",    {31'b0, ifa.load_err},       32'd1);
        chk("miss_pv",     {31'b0, ifa.params_valid},   32'd0);
        chk("miss_b1",     ba(1),                       32'h60000007);

        // Restart coincident with the accept of word 4.
        start_a();
        for (int i = 0; i < 4; i++) word_a(32'h50000000 + i, 1'b0);
        ifa.s_valid    = 1'b1;
        ifa.s_data     = 32'h50000004;
        ifa.load_start = 1'b1;
        tick();
        ifa.s_valid    = 1'b0;
        ifa.load_start = 1'b0;
        chk("rs_w4_kept",  wa(4),                       32'h60000004);
        chk("rs_ready",    {31'b0, ifa.s_ready},        32'd1);
        chk("rs_pv",       {31'b0, ifa.params_valid},   32'd0);
        for (int i = 0; i < 8; i++) begin
            word_a(32'hC0000000 + i, (i == 7));
            if (i == 5) chk("rs_w0", wa(0), 32'hC0000000);
        end
        chk("rs_pv_done",  {31'b0, ifa.params_valid},   32'd1);
        chk("rs_err",      {31'b0, ifa.load_err},       32'd0);
        chk("rs_w5",       wa(5),                       32'hC0000005);
        chk("rs_b1",       ba(1),                       32'hC0000007);

        // Default-size layer: 1008 weights + 24 biases.
        ifb.load_start = 1'b1;
        tick();
        ifb.load_start = 1'b0;
        for (int i = 0; i < 1032; i++) begin
            ifb.s_valid = 1'b1;
            ifb.s_data  = 32'h00001000 + i;
            ifb.s_last  = (i == 1031);
            tick();
            if (i == 1030) chk("big_pv_early", {31'b0, ifb.params_valid}, 32'd0);
        end
        ifb.s_valid = 1'b0;
        ifb.s_last  = 1'b0;
        chk("big_pv",      {31'b0, ifb.params_valid},   32'd1);
        chk("big_w1007",   ifb.weights[1007*32 +: 32],  32'h00001000 + 1007);
        chk("big_b23",     ifb.bias[23*32 +: 32],       32'h00001000 + 1031);

        // Single-neuron layer: 24 weights + 1 bias.
        ifc.load_start = 1'b1;
        tick();
        ifc.load_start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            ifc.s_valid = 1'b1;
            ifc.s_data  = 32'h00002000 + i;
            ifc.s_last  = (i == 24);
            tick();
        end
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
        chk("one_pv",      {31'b0, ifc.params_valid},   32'd1);
        chk("one_b0",      ifc.bias,                    32'h00002018);
        chk("one_w23",     ifc.weights[23*32 +: 32],    32'h00002017);
        chk("one_ready",   {31'b0, ifc.s_ready},        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
